// File: rtl/vga_pkg.sv
// Shared timing, colour and width constants for the 800x600@72 VGA path.
package vga_pkg;

    localparam int COORD_W = 11;

    // 800x600@72 horizontal timing, in pixel clocks
    localparam int H_VIS  = 800;
    localparam int H_FP   = 56;
    localparam int H_SYNC = 120;
    localparam int H_BP   = 64;

    // 800x600@72 vertical timing, in lines
    localparam int V_VIS  = 600;
    localparam int V_FP   = 37;
    localparam int V_SYNC = 6;
    localparam int V_BP   = 23;

    // RGB332 colours
    localparam logic [7:0] FG_RGB = 8'hFF;
    localparam logic [7:0] BG_RGB = 8'h03;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic {
        SCROLL_UP   = 1'b0,
        SCROLL_DOWN = 1'b1
    } scroll_state_e;

endpackage

// File: rtl/vga_scroll_ctrl.sv
// Logo scroll offset: bounces delt between 0 and DELT_MAX, one step per
// FRAME_DIV frame-end events, frozen while scroll_en is low.
module vga_scroll_ctrl
    import vga_pkg::*;
#(
    parameter int DELT_MAX  = 200,
    parameter int DELT_STEP = 2,
    parameter int FRAME_DIV = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   frame_end,
    input  logic   scroll_en,
    output coord_t delt
);

    localparam int     FDIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [FDIV_W-1:0] FDIV_LAST = FDIV_W'(FRAME_DIV - 1);
    localparam coord_t MAX_C     = coord_t'(DELT_MAX);
    localparam coord_t STEP_C    = coord_t'(DELT_STEP);

    scroll_state_e     state_q, state_d;
    coord_t            delt_q, delt_d;
    logic [FDIV_W-1:0] fdiv_q, fdiv_d;
    coord_t            delt_up;

    // Next offset / direction; everything holds unless an enabled frame end arrives
    always_comb begin
        state_d = state_q;
        delt_d  = delt_q;
        fdiv_d  = fdiv_q;
        delt_up = delt_q + STEP_C;
        if (frame_end && scroll_en) begin
            if (fdiv_q == FDIV_LAST) begin
                fdiv_d = '0;
                case (state_q)
                    SCROLL_UP: begin
                        if (delt_up >= MAX_C) begin
                            delt_d  = MAX_C;
                            state_d = SCROLL_DOWN;
                        end else begin
                            delt_d = delt_up;
                        end
                    end
                    SCROLL_DOWN: begin
                        if (delt_q <= STEP_C) begin
                            delt_d  = '0;
                            state_d = SCROLL_UP;
                        end else begin
                            delt_d = delt_q - STEP_C;
                        end
                    end
                    default: state_d = SCROLL_UP;
                endcase
            end else begin
                fdiv_d = fdiv_q + 1'b1;
            end
        end
    end

    // State, offset and divider registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCROLL_UP;
            delt_q  <= '0;
            fdiv_q  <= '0;
        end else begin
            state_q <= state_d;
            delt_q  <= delt_d;
            fdiv_q  <= fdiv_d;
        end
    end

    assign delt = delt_q;

endmodule

// File: rtl/vga_scan_driver.sv
// VGA raster scan: stage-0 h/v counters drive x/y/delt to the painters,
// stage-1 registers turn the returned hit into aligned rgb/de/hsync/vsync.
module vga_scan_driver
    import vga_pkg::*;
#(
    parameter int   H_VIS_P   = H_VIS,
    parameter int   H_FP_P    = H_FP,
    parameter int   H_SYNC_P  = H_SYNC,
    parameter int   H_BP_P    = H_BP,
    parameter int   V_VIS_P   = V_VIS,
    parameter int   V_FP_P    = V_FP,
    parameter int   V_SYNC_P  = V_SYNC,
    parameter int   V_BP_P    = V_BP,
    parameter logic SYNC_POL  = 1'b1,
    parameter int   DELT_MAX  = 200,
    parameter int   DELT_STEP = 2,
    parameter int   FRAME_DIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scroll_en,
    input  logic               hit,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [COORD_W-1:0] delt,
    output logic [7:0]         rgb,
    output logic               hsync,
    output logic               vsync,
    output logic               de
);

    localparam coord_t H_VIS_C  = coord_t'(H_VIS_P);
    localparam coord_t HS_BEG_C = coord_t'(H_VIS_P + H_FP_P);
    localparam coord_t HS_END_C = coord_t'(H_VIS_P + H_FP_P + H_SYNC_P);
    localparam coord_t H_LAST_C = coord_t'(H_VIS_P + H_FP_P + H_SYNC_P + H_BP_P - 1);
    localparam coord_t V_VIS_C  = coord_t'(V_VIS_P);
    localparam coord_t VS_BEG_C = coord_t'(V_VIS_P + V_FP_P);
    localparam coord_t VS_END_C = coord_t'(V_VIS_P + V_FP_P + V_SYNC_P);
    localparam coord_t V_LAST_C = coord_t'(V_VIS_P + V_FP_P + V_SYNC_P + V_BP_P - 1);

    coord_t     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [7:0] rgb_q, rgb_d;
    logic       de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic       active, frame_end;

    // Raster counters: column wraps every line, line wraps every frame
    always_comb begin
        h_cnt_d   = h_cnt_q + 1'b1;
        v_cnt_d   = v_cnt_q;
        frame_end = (h_cnt_q == H_LAST_C) && (v_cnt_q == V_LAST_C);
        if (h_cnt_q == H_LAST_C) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST_C) ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Stage-1 pixel/sync values from the current counters and painter hit
    always_comb begin
        active  = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
        de_d    = active;
        rgb_d   = active ? (hit ? FG_RGB : BG_RGB) : 8'h00;
        hsync_d = ((h_cnt_q >= HS_BEG_C) && (h_cnt_q < HS_END_C)) ? SYNC_POL : !SYNC_POL;
        vsync_d = ((v_cnt_q >= VS_BEG_C) && (v_cnt_q < VS_END_C)) ? SYNC_POL : !SYNC_POL;
    end

    // Counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            rgb_q   <= '0;
            de_q    <= 1'b0;
            hsync_q <= !SYNC_POL;
            vsync_q <= !SYNC_POL;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            rgb_q   <= rgb_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    vga_scroll_ctrl #(
        .DELT_MAX  (DELT_MAX),
        .DELT_STEP (DELT_STEP),
        .FRAME_DIV (FRAME_DIV)
    ) u_scroll (
        .clk       (clk),
        .rst       (rst),
        .frame_end (frame_end),
        .scroll_en (scroll_en),
        .delt      (delt)
    );

    assign x     = h_cnt_q;
    assign y     = v_cnt_q;
    assign rgb   = rgb_q;
    assign de    = de_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver on a scaled-down raster so whole frames fit in a
// short run; a frame-level reference model predicts every output each cycle.
module tb_vga_scan_driver;

    localparam int HV = 16, HF = 3, HS = 5, HB = 4, HT = HV + HF + HS + HB;
    localparam int VV = 10, VF = 2, VS = 3, VB = 2, VT = VV + VF + VS + VB;
    localparam int DMAX = 5, DSTEP = 2, FDIV = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scroll_en = 1'b0;
    logic        hit = 1'b0;
    logic [10:0] x, y, delt;
    logic [7:0]  rgb;
    logic        hsync, vsync, de;

    int errs = 0;
    int checks = 0;

    // reference model state
    int   mx = 0, my = 0, mdelt = 0, mfc = 0;
    bit   mup = 1'b1;
    int   hit_mode = 0;
    logic [7:0] e_rgb = 8'h00;
    logic e_de = 1'b0, e_hs = 1'b0, e_vs = 1'b0;

    always #10 clk = ~clk;

    vga_scan_driver #(
        .H_VIS_P(HV), .H_FP_P(HF), .H_SYNC_P(HS), .H_BP_P(HB),
        .V_VIS_P(VV), .V_FP_P(VF), .V_SYNC_P(VS), .V_BP_P(VB),
        .SYNC_POL(1'b1), .DELT_MAX(DMAX), .DELT_STEP(DSTEP), .FRAME_DIV(FDIV)
    ) dut (
        .clk(clk), .rst(rst), .scroll_en(scroll_en), .hit(hit),
        .x(x), .y(y), .delt(delt), .rgb(rgb),
        .hsync(hsync), .vsync(vsync), .de(de)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $display("FAIL %s: observed %0d expected %0d (mx=%0d my=%0d)", tag, obs, exp, mx, my);
            $error("check %s", tag);
        end
    endtask

    // one pixel clock: drive hit, predict the edge, then compare on the falling edge
    task automatic step();
        hit = (hit_mode != 0) ? (mx == 5) : 1'($urandom_range(0, 1));
        if (rst) begin
            mx = 0; my = 0; mdelt = 0; mup = 1'b1; mfc = 0;
            e_rgb = 8'h00; e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0;
        end else begin
            e_de  = (mx < HV) && (my < VV);
            e_rgb = e_de ? (hit ? 8'hFF : 8'h03) : 8'h00;
            e_hs  = (mx >= HV + HF) && (mx < HV + HF + HS);
            e_vs  = (my >= VV + VF) && (my < VV + VF + VS);
            if (mx == HT - 1 && my == VT - 1 && scroll_en) begin
                mfc++;
                if (mfc == FDIV) begin
                    mfc = 0;
                    if (mup) begin
                        if (mdelt + DSTEP >= DMAX) begin mdelt = DMAX; mup = 1'b0; end
                        else mdelt = mdelt + DSTEP;
                    end else begin
                        if (mdelt <= DSTEP) begin mdelt = 0; mup = 1'b1; end
                        else mdelt = mdelt - DSTEP;
                    end
                end
            end
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("x", 32'(x), 32'(mx));
        chk("y", 32'(y), 32'(my));
        chk("delt", 32'(delt), 32'(mdelt));
        chk("rgb", 32'(rgb), 32'(e_rgb));
        chk("de", 32'(de), 32'(e_de));
        chk("hsync", 32'(hsync), 32'(e_hs));
        chk("vsync", 32'(vsync), 32'(e_vs));
    endtask

    task automatic run_frame();
        repeat (HT * VT) step();
    endtask

    initial begin
        int seq [7];
        seq = '{2, 4, 5, 3, 1, 0, 2};

        // reset held five clocks, then the first free-running edge lands on x=1
        rst = 1'b1;
        repeat (5) step();
        rst = 1'b0;
        scroll_en = 1'b1;
        step();
        chk("first_x_after_reset", 32'(x), 32'd1);
        repeat (HT * VT - 1) step();
        chk("bounce_f1", 32'(delt), 32'(seq[0]));

        // bounce sequence across frames
        for (int f = 1; f < 7; f++) begin
            run_frame();
            chk("bounce_seq", 32'(delt), 32'(seq[f]));
        end

        // freeze at 4 for three frames, then resume to 5
        run_frame();
        chk("pre_freeze", 32'(delt), 32'd4);
        scroll_en = 1'b0;
        repeat (3) begin
            run_frame();
            chk("freeze_hold", 32'(delt), 32'd4);
        end
        scroll_en = 1'b1;
        run_frame();
        chk("freeze_resume", 32'(delt), 32'd5);

        // hit tied to one column
        hit_mode = 1;
        run_frame();
        hit_mode = 0;

        // random enable per frame, random hit
        repeat (4) begin
            scroll_en = 1'($urandom_range(0, 1));
            run_frame();
        end
        scroll_en = 1'b1;

        // reset in the middle of a visible line
        for (int i = 0; i < 2 * HT * VT; i++) begin
            if (my == VV / 2 && mx == 3) break;
            step();
        end
        chk("mid_reset_reached", 32'(my), 32'(VV / 2));
        rst = 1'b1;
        repeat (2) step();
        chk("mid_reset_x", 32'(x), 32'd0);
        chk("mid_reset_y", 32'(y), 32'd0);
        chk("mid_reset_delt", 32'(delt), 32'd0);
        rst = 1'b0;
        run_frame();
        chk("post_reset_delt", 32'(delt), 32'd2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/vga_scan_driver.md
# vga_scan_driver

Pixel-scan driver for the 800x600 VGA output path. It generates the raster coordinates `x`, `y` and the logo scroll offset `delt` that the combinational logo painters consume. It takes their wired-OR `hit` result back and emits one-cycle-aligned RGB, HSYNC, VSYNC and data-enable to the DAC pins. It is the producer/consumer at the other end of the painter interface: painters map (x, y, delt) to hit, and this block drives (x, y, delt) and turns hit into pixels.

## Interface
- H_VIS, 800, visible pixels per line
- H_FP, 56, horizontal front porch
- H_SYNC, 120, hsync width
- H_BP, 64, horizontal back porch (H_TOTAL = 1040)
- V_VIS, 600, visible lines
- V_FP, 37, vertical front porch
- V_SYNC, 6, vsync width
- V_BP, 23, vertical back porch (V_TOTAL = 666)
- SYNC_POL, 1, active level of hsync/vsync
- DELT_MAX, 200, upper bound of scroll offset
- DELT_STEP, 2, offset change per update
- FRAME_DIV, 1, frames per offset update (≥1)
- FG_RGB, 8'hFF, colour when hit; BG_RGB, 8'h03, colour when not hit in the visible area

Ports:
- clk  in  1  pixel clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- scroll_en  in  1  offset animation enable
- hit  in  1  combinational painter result for the current `x`, `y`, `delt`
- x  out  11  current column counter
- y  out  11  current line counter
- delt  out  11  scroll offset
- rgb  out  8  {R[2:0],G[2:0],B[1:0]}
- hsync  out  1
- vsync  out  1
- de  out  1  registered visible-area flag, aligned with `rgb`

## Operation
- Stage 0 has two registered counters, `h_cnt` and `v_cnt`. These drive `x` and `y` directly.
  - `h_cnt` increments every clock. At H_TOTAL-1 it wraps to 0, and `v_cnt` increments.
  - At V_TOTAL-1, `v_cnt` wraps to 0.
- active = (h_cnt < H_VIS) && (v_cnt < V_VIS).
- Stage 1 registers, from stage-0 values plus the `hit` input:
  - `de` <= active
  - `rgb` <= active ? (hit ? FG_RGB : BG_RGB) : 0
  - `hsync` <= SYNC_POL when H_VIS+H_FP ≤ h_cnt < H_VIS+H_FP+H_SYNC, else !SYNC_POL
  - `vsync` <= SYNC_POL when V_VIS+V_FP ≤ v_cnt < V_VIS+V_FP+V_SYNC, else !SYNC_POL
- Scroll FSM has two states, UP and DOWN, plus a frame-divider counter `fdiv`.
  - Frame-end event: h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1, with scroll_en = 1.
  - On each frame-end event, `fdiv` increments. When `fdiv` reaches FRAME_DIV-1 it clears and an update fires.
  - UP update: if delt+DELT_STEP ≥ DELT_MAX, then delt <= DELT_MAX and go to DOWN. Otherwise delt += DELT_STEP.
  - DOWN update: if delt ≤ DELT_STEP, then delt <= 0 and go to UP. Otherwise delt -= DELT_STEP.
  - With scroll_en = 0, `delt`, the state and `fdiv` all hold. Counters and syncs keep running.
- All arithmetic is unsigned 11-bit. The clamps above mean `delt` never exceeds DELT_MAX and never underflows.

## Timing
- Reset values:
  - h_cnt = v_cnt = 0, so x = y = 0
  - delt = 0, state UP, fdiv = 0
  - rgb = 0, de = 0
  - hsync = vsync = !SYNC_POL
- Reset asserted mid-frame: all of the above take effect on the next edge. The first post-reset cycle is pixel (0,0).
- Latency: `rgb`, `de`, `hsync` and `vsync` lag `x`/`y` by exactly 1 clock. All four outputs share that lag, so they stay mutually aligned.
- `hit` must settle within the same cycle as `x`, `y`, `delt`. It is sampled on the next edge.
- `delt` changes only on the edge where the counters wrap to (0,0). It is therefore constant across every visible frame.
- Frame length is 692,640 clocks.

## Structure
- Shared package `vga_pkg`: the 800x600@72 timing constants, the RGB332 colour constants, and the 11-bit coordinate width.
- One natural sub-module, `vga_scroll_ctrl`: the UP/DOWN FSM plus `fdiv`, with inputs frame_end and scroll_en and output delt.
- Counters and the stage-1 output register stay in the top level.

## Test plan
- Reset: hold rst for 5 clocks, then release.
  - During reset: x = y = 0, rgb = 0, de = 0, hsync = vsync = 0 (SYNC_POL = 1).
  - First edge after release: x = 1.
- Line timing: the edge after x = 856 gives hsync = 1.
  - hsync stays high for 120 clocks and falls on the edge after x = 976.
  - de is high for exactly 800 clocks per visible line.
- Frame timing: vsync rises on the edge after (x = 0, y = 637) and lasts 6 × 1040 clocks. After y = 665, x = 1039 the counters return to (0,0).
- Hit alignment: tie hit = (x == 510).
  - rgb = 8'hFF only in the cycle after x = 510.
  - rgb = 8'h03 elsewhere in the visible area.
  - rgb = 0 in blanking.
- Scroll bounce: scroll_en = 1, DELT_MAX = 5, DELT_STEP = 2, FRAME_DIV = 1.
  - delt per frame: 0, 2, 4, 5, 3, 1, 0, 2, …
  - delt changes only at the (0,0) wrap.
- Scroll freeze: drop scroll_en at delt = 4 for 3 frames, then raise it. delt holds 4, then goes to 5.
- Also: reset mid-frame at y = 300 returns to (0,0) with delt = 0.
